// File: rtl/sobel_feeder.sv
// Scans a frame in 3-column vertical strips and serialises it as Sobel windows with start/finish framing.
// Memory read is issued 2 cycles ahead of each pixel slot; the stream runs at a fixed cadence with no backpressure.
module sobel_feeder #(
    parameter int PIXEL_WIDTH_OUT = 8,
    parameter int IMG_WIDTH       = 16,
    parameter int IMG_HEIGHT      = 16,
    parameter int ADDR_WIDTH      = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       start_frame_i,
    output logic                       mem_rd_o,
    output logic [ADDR_WIDTH-1:0]      mem_addr_o,
    input  logic [PIXEL_WIDTH_OUT-1:0] mem_data_i,
    output logic                       start_o,
    output logic                       finish_o,
    output logic [PIXEL_WIDTH_OUT-1:0] out_px_gray_o,
    output logic                       busy_o,
    output logic                       frame_done_o
);

    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam int COL_W = (IMG_WIDTH > 3) ? $clog2(IMG_WIDTH - 2) : 1;

    typedef enum logic [2:0] {
        IDLE,
        PREFETCH,
        FIRST_WIN,
        NEXT_WIN,
        FINISH,
        GAP
    } state_t;

    state_t                     state_q;
    state_t                     state_d;
    logic [3:0]                 slot_q;
    logic [3:0]                 slot_d;
    logic [ROW_W-1:0]           row_q;
    logic [1:0]                 j_q;
    logic [COL_W-1:0]           col_q;
    logic [ADDR_WIDTH-1:0]      row_base_q;
    logic [ADDR_WIDTH-1:0]      addr_hold_q;
    logic [ADDR_WIDTH-1:0]      rd_addr;
    logic                       rd_en;
    logic                       rd_q;
    logic [PIXEL_WIDTH_OUT-1:0] px_q;

    // Reads walk the strip strictly row-major, so one pointer (row, j) serves every read.
    assign rd_addr = row_base_q + ADDR_WIDTH'(col_q) + ADDR_WIDTH'(j_q);

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        rd_en        = 1'b0;
        start_o      = 1'b0;
        finish_o     = 1'b0;
        frame_done_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                slot_d = 4'd0;
                if (start_frame_i) begin
                    state_d = PREFETCH;
                end
            end
            PREFETCH: begin
                rd_en   = 1'b1;
                slot_d  = 4'd0;
                state_d = FIRST_WIN;
            end
            FIRST_WIN: begin
                start_o = (slot_q == 4'd0);
                rd_en   = (slot_q != 4'd8);
                if (slot_q == 4'd9) begin
                    slot_d  = 4'd0;
                    state_d = NEXT_WIN;
                end else begin
                    slot_d = slot_q + 4'd1;
                end
            end
            NEXT_WIN: begin
                slot_d = (slot_q == 4'd3) ? 4'd0 : slot_q + 4'd1;
                // Phase 3 prefetches the next row's first column; row pointer back at 0 means the strip is fully read.
                unique case (slot_q)
                    4'd0, 4'd1: rd_en = 1'b1;
                    4'd3:       rd_en = (row_q != '0);
                    default:    rd_en = 1'b0;
                endcase
                if (slot_q == 4'd3 && row_q == '0) begin
                    slot_d  = 4'd0;
                    state_d = FINISH;
                end
            end
            FINISH: begin
                finish_o = 1'b1;
                slot_d   = 4'd0;
                state_d  = GAP;
            end
            GAP: begin
                slot_d = 4'd0;
                // The column base has already wrapped to 0 after the last strip's final read.
                if (col_q != '0) begin
                    rd_en   = 1'b1;
                    state_d = FIRST_WIN;
                end else begin
                    frame_done_o = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            slot_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            row_q       <= '0;
            j_q         <= 2'd0;
            col_q       <= '0;
            row_base_q  <= '0;
            addr_hold_q <= '0;
        end else if (rd_en) begin
            addr_hold_q <= rd_addr;
            if (j_q == 2'd2) begin
                j_q <= 2'd0;
                if (row_q == ROW_W'(IMG_HEIGHT - 1)) begin
                    row_q      <= '0;
                    row_base_q <= '0;
                    col_q      <= (col_q == COL_W'(IMG_WIDTH - 3)) ? '0 : col_q + COL_W'(1);
                end else begin
                    row_q      <= row_q + ROW_W'(1);
                    row_base_q <= row_base_q + ADDR_WIDTH'(IMG_WIDTH);
                end
            end else begin
                j_q <= j_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_q <= 1'b0;
            px_q <= '0;
        end else begin
            rd_q <= rd_en;
            px_q <= rd_q ? mem_data_i : '0;
        end
    end

    assign mem_rd_o      = rd_en;
    assign mem_addr_o    = rd_en ? rd_addr : addr_hold_q;
    assign out_px_gray_o = px_q;
    assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_sobel_feeder.sv
// Bench for sobel_feeder: a 3x4 and a 5x4 instance share stimulus; a per-cycle scoreboard built from the
// strip timing formulas plus a table of spot vectors against a captured trace.
`timescale 1ns/1ps
module tb_sobel_feeder;

    localparam int H = 4;
    localparam logic [20:0] IDLE_MASK = 21'h1F00FF;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_frame = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rd3, st3, fi3, busy3, dn3;
    logic [7:0] addr3, data3, px3;
    logic       rd5, st5, fi5, busy5, dn5;
    logic [7:0] addr5, data5, px5;

    sobel_feeder #(.PIXEL_WIDTH_OUT(8), .IMG_WIDTH(3), .IMG_HEIGHT(H), .ADDR_WIDTH(8)) dut3 (
        .clk_i(clk), .reset_i(reset), .start_frame_i(start_frame),
        .mem_rd_o(rd3), .mem_addr_o(addr3), .mem_data_i(data3),
        .start_o(st3), .finish_o(fi3), .out_px_gray_o(px3),
        .busy_o(busy3), .frame_done_o(dn3));

    sobel_feeder #(.PIXEL_WIDTH_OUT(8), .IMG_WIDTH(5), .IMG_HEIGHT(H), .ADDR_WIDTH(8)) dut5 (
        .clk_i(clk), .reset_i(reset), .start_frame_i(start_frame),
        .mem_rd_o(rd5), .mem_addr_o(addr5), .mem_data_i(data5),
        .start_o(st5), .finish_o(fi5), .out_px_gray_o(px5),
        .busy_o(busy5), .frame_done_o(dn5));

    // Memory word = its address; unread cycles return a marker so a leaked dummy slot is visible.
    always @(posedge clk) data3 <= rd3 ? addr3 : 8'hEE;
    always @(posedge clk) data5 <= rd5 ? addr5 : 8'hEE;

    logic [20:0] obs3, obs5;
    assign obs3 = {st3, fi3, dn3, busy3, rd3, addr3, px3};
    assign obs5 = {st5, fi5, dn5, busy5, rd5, addr5, px5};

    typedef struct { int cyc; logic [20:0] exp; } rec_t;
    typedef struct { int which; int rel; logic [3:0] flags; logic [7:0] px; } vec_t;

    rec_t q3[$];
    rec_t q5[$];
    vec_t tbl[$];

    int pass_cnt = 0;
    int chk_cnt = 0;
    bit mon_en = 1'b0;
    bit rec_on = 1'b0;
    int rec_a = 0;
    int rdcnt3 = 0;
    int rdcnt5 = 0;
    logic [20:0] tr3 [0:63];
    logic [20:0] tr5 [0:63];

    task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected per-cycle outputs for one frame accepted at cycle a (records cover a+1 .. busy-low cycle).
    task automatic push_frame(input int which, input int a);
        int w, p, last, b, idx;
        bit st [0:63];
        bit fi [0:63];
        bit dn [0:63];
        bit rd [0:63];
        int px [0:63];
        int ad [0:63];
        rec_t r;
        w = (which == 0) ? 3 : 5;
        p = (w - 2) * 4 * H + 2;
        for (int i = 0; i < 64; i++) begin
            st[i] = 1'b0; fi[i] = 1'b0; dn[i] = 1'b0; rd[i] = 1'b0; px[i] = 0; ad[i] = 0;
        end
        for (int s = 0; s < w - 2; s++) begin
            b = 1 + 4 * H * s;
            st[b] = 1'b1;
            fi[b + 4 * H - 2] = 1'b1;
            for (int k = 0; k < 9; k++) begin
                idx = b + 1 + k;
                px[idx] = (k / 3) * w + s + (k % 3);
                rd[idx - 2] = 1'b1;
                ad[idx - 2] = px[idx];
            end
            for (int n = 1; n <= H - 3; n++) begin
                for (int j = 0; j < 3; j++) begin
                    idx = b + 4 * n + 7 + j;
                    px[idx] = (n + 2) * w + s + j;
                    rd[idx - 2] = 1'b1;
                    ad[idx - 2] = px[idx];
                end
            end
        end
        dn[p - 2] = 1'b1;
        last = 0;
        for (int i = 0; i < p; i++) begin
            if (rd[i]) last = ad[i];
            r.cyc = a + 1 + i;
            r.exp = {st[i], fi[i], dn[i], (i < p - 1), rd[i], 8'(last), 8'(px[i])};
            if (which == 0) q3.push_back(r);
            else q5.push_back(r);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((q3.size() != 0 || q5.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout", 21'(q3.size() + q5.size()), 21'd0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (q3.size() != 0 && q3[0].cyc <= cyc) begin
                check("stream3", obs3, q3[0].exp);
                void'(q3.pop_front());
            end else begin
                check("idle3", obs3 & IDLE_MASK, 21'd0);
            end
            if (q5.size() != 0 && q5[0].cyc <= cyc) begin
                check("stream5", obs5, q5[0].exp);
                void'(q5.pop_front());
            end else begin
                check("idle5", obs5 & IDLE_MASK, 21'd0);
            end
            if (rec_on && (cyc - rec_a) >= 0 && (cyc - rec_a) < 64) begin
                tr3[cyc - rec_a] = obs3;
                tr5[cyc - rec_a] = obs5;
                if (rd3) rdcnt3++;
                if (rd5) rdcnt5++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, chk_cnt);
        $fatal(1);
    end

    initial begin
        int a;
        logic [20:0] t;
        // {dut (0=3x4, 1=5x4), cycle relative to accept, {start,finish,done,busy}, pixel}
        tbl.push_back('{0,  0, 4'b0000, 8'd0});
        tbl.push_back('{0,  2, 4'b1001, 8'd0});
        tbl.push_back('{0,  3, 4'b0001, 8'd0});
        tbl.push_back('{0,  4, 4'b0001, 8'd1});
        tbl.push_back('{0, 11, 4'b0001, 8'd8});
        tbl.push_back('{0, 12, 4'b0001, 8'd0});
        tbl.push_back('{0, 13, 4'b0001, 8'd9});
        tbl.push_back('{0, 15, 4'b0001, 8'd11});
        tbl.push_back('{0, 16, 4'b0101, 8'd0});
        tbl.push_back('{0, 17, 4'b0011, 8'd0});
        tbl.push_back('{0, 18, 4'b0000, 8'd0});
        tbl.push_back('{1,  2, 4'b1001, 8'd0});
        tbl.push_back('{1, 17, 4'b0001, 8'd0});
        tbl.push_back('{1, 18, 4'b1001, 8'd0});
        tbl.push_back('{1, 19, 4'b0001, 8'd1});
        tbl.push_back('{1, 22, 4'b0001, 8'd6});
        tbl.push_back('{1, 27, 4'b0001, 8'd13});
        tbl.push_back('{1, 28, 4'b0001, 8'd0});
        tbl.push_back('{1, 31, 4'b0001, 8'd18});
        tbl.push_back('{1, 32, 4'b0101, 8'd0});
        tbl.push_back('{1, 34, 4'b1001, 8'd0});
        tbl.push_back('{1, 35, 4'b0001, 8'd2});
        tbl.push_back('{1, 47, 4'b0001, 8'd19});
        tbl.push_back('{1, 48, 4'b0101, 8'd0});
        tbl.push_back('{1, 49, 4'b0011, 8'd0});
        tbl.push_back('{1, 50, 4'b0000, 8'd0});

        // Reset for 3 cycles, then idle for 5.
        reset = 1'b1;
        start_frame = 1'b0;
        tick();
        mon_en = 1'b1;
        check("reset_obs3", obs3, 21'd0);
        check("reset_obs5", obs5, 21'd0);
        tick();
        tick();
        reset = 1'b0;
        repeat (5) tick();

        // One frame on both instances: single strip (3x4) and three strips (5x4).
        start_frame = 1'b1;
        a = cyc;
        push_frame(0, a);
        push_frame(1, a);
        rec_a = a;
        rdcnt3 = 0;
        rdcnt5 = 0;
        rec_on = 1'b1;
        tick();
        start_frame = 1'b0;
        wait_drain(200);
        rec_on = 1'b0;
        foreach (tbl[i]) begin
            t = (tbl[i].which == 0) ? tr3[tbl[i].rel] : tr5[tbl[i].rel];
            check($sformatf("vec%0d_dut%0d_rel%0d", i, tbl[i].which, tbl[i].rel),
                  21'({t[20:17], t[7:0]}), 21'({tbl[i].flags, tbl[i].px}));
        end
        check("reads_3x4", 21'(rdcnt3), 21'd12);
        check("reads_5x4", 21'(rdcnt5), 21'd36);
        repeat (3) tick();

        // start_frame held for 60 cycles: ignored while busy, re-accepted the cycle busy falls.
        start_frame = 1'b1;
        a = cyc;
        for (int s = a; s < a + 60; s += 18) push_frame(0, s);
        for (int s = a; s < a + 60; s += 50) push_frame(1, s);
        repeat (60) tick();
        start_frame = 1'b0;
        wait_drain(300);
        repeat (3) tick();

        // Reset at relative cycle 7 of strip 1 of the 5x4 frame, then a fresh frame.
        start_frame = 1'b1;
        a = cyc;
        push_frame(0, a);
        push_frame(1, a);
        tick();
        start_frame = 1'b0;
        while (cyc < a + 25) tick();
        reset = 1'b1;
        tick();
        q3.delete();
        q5.delete();
        reset = 1'b0;
        check("midreset_obs5", obs5, 21'd0);
        check("midreset_obs3", obs3, 21'd0);
        repeat (6) tick();
        start_frame = 1'b1;
        a = cyc;
        push_frame(0, a);
        push_frame(1, a);
        tick();
        start_frame = 1'b0;
        wait_drain(200);
        repeat (3) tick();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
